// File: rtl/prach_reshape_iq.sv
// prach_reshape_iq: turns grouped real/imag input slots into complex output channels through a ping-pong buffer.
// Define PRACH_RESHAPE_IQ_DV_CHECK_EN to AND the real/imag valids and flag any disagreement between them.
module prach_reshape_iq #(
    parameter int DW      = 16,
    parameter int NUM_CHN = 24,
    parameter int GROUP   = 8,
    parameter int FRAME   = 256,
    parameter int CHN_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    din_dq,
    input  logic             din_dv,
    input  logic [CHN_W-1:0] din_chn,
    input  logic             sync_in,
    output logic [DW-1:0]    dout_dr,
    output logic [DW-1:0]    dout_di,
    output logic             dout_dv,
    output logic             sync_out,
    output logic [CHN_W-1:0] dout_chn,
    output logic             err_overrun,
    output logic             err_dv_mismatch
);
    localparam int SLOTS = 2 * NUM_CHN;
    localparam int AW    = $clog2(SLOTS);

    if (NUM_CHN % GROUP != 0 || NUM_CHN > FRAME || FRAME > 2**CHN_W || SLOTS > 2**CHN_W) begin : g_bad_cfg
        $error("prach_reshape_iq: illegal parameter combination");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_wbank;
    logic [CHN_W-1:0] r_cnt;
    logic [DW+1:0]    r_mem [2][SLOTS];
    logic             w_last, w_rd, w_dv, w_mis, w_unused;
    logic [AW-1:0]    w_re_addr, w_im_addr;
    logic [DW+1:0]    w_re, w_im;
    logic [CHN_W-1:0] r_p_chn;
    logic [DW-1:0]    r_p_dr, r_p_di;
    logic             r_p_dv, r_p_sync, r_p_mis;

    assign w_last    = din_chn == CHN_W'(SLOTS - 1);
    assign w_rd      = r_state == RUN && r_cnt < CHN_W'(NUM_CHN);
    // entries are {sync, dv, dq}; imag of a channel sits GROUP slots after its real
    assign w_re_addr = w_rd ? AW'(int'(r_cnt) / GROUP * 2 * GROUP + int'(r_cnt) % GROUP) : '0;
    assign w_im_addr = w_re_addr + AW'(GROUP);
    assign w_re      = r_mem[~r_wbank][w_re_addr];
    assign w_im      = r_mem[~r_wbank][w_im_addr];
`ifdef PRACH_RESHAPE_IQ_DV_CHECK_EN
    assign w_dv      = w_re[DW] & w_im[DW];
    assign w_mis     = w_rd & (w_re[DW] ^ w_im[DW]);
`else
    assign w_dv      = w_re[DW];
    assign w_mis     = 1'b0;
`endif
    assign w_unused  = &{1'b0, w_im[DW+1:DW]};

    always_comb w_state_nxt = w_last ? RUN : r_state;

    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_state_nxt;

    always_ff @(posedge clk)
        if ({1'b0, din_chn} < (CHN_W + 1)'(SLOTS))
            r_mem[r_wbank][din_chn[AW-1:0]] <= {sync_in, din_dv, din_dq};

    // two-stage readout: buffer read register, then output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbank         <= 1'b0;
            r_cnt           <= '0;
            r_p_chn         <= '0;
            r_p_dr          <= '0;
            r_p_di          <= '0;
            r_p_dv          <= 1'b0;
            r_p_sync        <= 1'b0;
            r_p_mis         <= 1'b0;
            dout_dr         <= '0;
            dout_di         <= '0;
            dout_dv         <= 1'b0;
            sync_out        <= 1'b0;
            dout_chn        <= '0;
            err_overrun     <= 1'b0;
            err_dv_mismatch <= 1'b0;
        end else begin
            r_wbank         <= r_wbank ^ w_last;
            r_cnt           <= (w_last || r_state == IDLE || r_cnt == CHN_W'(FRAME - 1)) ? '0 : r_cnt + CHN_W'(1);
            err_overrun     <= w_last && r_state == RUN && r_cnt < CHN_W'(NUM_CHN - 1);
            r_p_chn         <= r_state == RUN ? r_cnt : '0;
            r_p_dr          <= w_rd ? w_re[DW-1:0] : '0;
            r_p_di          <= w_rd ? w_im[DW-1:0] : '0;
            r_p_dv          <= w_rd & w_dv;
            r_p_sync        <= w_rd & w_re[DW+1];
            r_p_mis         <= w_mis;
            dout_dr         <= r_p_dr;
            dout_di         <= r_p_di;
            dout_dv         <= r_p_dv;
            sync_out        <= r_p_sync;
            dout_chn        <= r_p_chn;
            err_dv_mismatch <= r_p_mis;
        end
    end
endmodule

// File: tb/tb_prach_reshape_iq.sv
// tb_prach_reshape_iq: random slot streams checked every cycle against a frame-level reference model.
module tb_prach_reshape_iq;
    localparam int DW = 16, NUM_CHN = 24, GROUP = 8, FRAME = 256, CHN_W = 8;
    localparam int SLOTS = 2 * NUM_CHN;

    logic             clk = 1'b0, rst = 1'b1;
    logic [DW-1:0]    din_dq = '0;
    logic             din_dv = 1'b0, sync_in = 1'b0;
    logic [CHN_W-1:0] din_chn = '0;
    logic [DW-1:0]    dout_dr, dout_di;
    logic             dout_dv, sync_out, err_overrun, err_dv_mismatch;
    logic [CHN_W-1:0] dout_chn;

    int n_tests = 0, n_fail = 0, edge_n = 0, wb = 0;
    int sw[3] = '{-1, -1, -1};
    logic [DW+1:0] mbank [2][SLOTS];
    logic [DW+1:0] snap  [3][SLOTS];

    prach_reshape_iq #(.DW(DW), .NUM_CHN(NUM_CHN), .GROUP(GROUP), .FRAME(FRAME), .CHN_W(CHN_W)) dut (
        .clk(clk), .rst(rst), .din_dq(din_dq), .din_dv(din_dv), .din_chn(din_chn), .sync_in(sync_in),
        .dout_dr(dout_dr), .dout_di(dout_di), .dout_dv(dout_dv), .sync_out(sync_out), .dout_chn(dout_chn),
        .err_overrun(err_overrun), .err_dv_mismatch(err_dv_mismatch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One slot per edge; the model records completed frames and derives each output from the
    // distance to the most recent frame completion.
    task automatic step(input logic r, input int chn, input logic [DW-1:0] dq, input logic dv, input logic sy);
        int j, i_sw, ra;
        logic [DW+1:0] re, im;
        logic e_ovr, e_dv, e_mis;
        rst = r; din_chn = CHN_W'(chn); din_dq = dq; din_dv = dv; sync_in = sy;
        @(posedge clk);
        e_ovr = 1'b0;
        if (chn < SLOTS) mbank[wb][chn] = {sy, dv, dq};
        if (r) begin
            wb = 0;
            sw = '{-1, -1, -1};
        end else if (chn == SLOTS - 1) begin
            e_ovr = sw[0] >= 0 && (edge_n - 1 - sw[0]) % FRAME < NUM_CHN - 1;
            sw[2] = sw[1]; sw[1] = sw[0]; sw[0] = edge_n;
            for (int k = 0; k < SLOTS; k++) begin
                snap[2][k] = snap[1][k];
                snap[1][k] = snap[0][k];
                snap[0][k] = mbank[wb][k];
            end
            wb = 1 - wb;
        end
        i_sw = -1;
        if (!r)
            for (int i = 2; i >= 0; i--)
                if (sw[i] >= 0 && sw[i] <= edge_n - 2) i_sw = i;
        j = 0; re = '0; im = '0;
        if (i_sw >= 0) begin
            j = (edge_n - 2 - sw[i_sw]) % FRAME;
            if (j < NUM_CHN) begin
                ra = j / GROUP * 2 * GROUP + j % GROUP;
                re = snap[i_sw][ra];
                im = snap[i_sw][ra + GROUP];
            end
        end
`ifdef PRACH_RESHAPE_IQ_DV_CHECK_EN
        e_dv = re[DW] & im[DW];
        e_mis = re[DW] ^ im[DW];
`else
        e_dv = re[DW];
        e_mis = 1'b0;
`endif
        #1;
        check("dout_dr", dout_dr, re[DW-1:0]);
        check("dout_di", dout_di, im[DW-1:0]);
        check("dout_dv", dout_dv, e_dv);
        check("sync_out", sync_out, re[DW+1]);
        check("dout_chn", dout_chn, j);
        check("err_overrun", err_overrun, e_ovr);
        check("err_dv_mismatch", err_dv_mismatch, e_mis);
        edge_n++;
        @(negedge clk);
    endtask

    // hole < 0: random valids; otherwise all valid except slot 'hole'
    task automatic frame(input int hole);
        for (int t = 0; t < FRAME; t++)
            step(1'b0, t, DW'($urandom), hole >= 0 ? (t != hole) : ($urandom_range(0, 7) != 0),
                 $urandom_range(0, 3) == 0);
    endtask

    initial begin
        repeat (3) step(1'b1, 0, '0, 1'b0, 1'b0);
        for (int t = 0; t < FRAME; t++) begin
            step(1'b0, t, DW'(t), 1'b1, t == 0);
            if (t == SLOTS - 1 + 11) begin
                check("ch9_dr", dout_dr, 17);
                check("ch9_di", dout_di, 25);
                check("ch9_chn", dout_chn, 9);
            end
        end
        repeat (3) frame(-1);
        frame(12);
        for (int t = 0; t < SLOTS + 9; t++) step(1'b0, t, DW'($urandom), 1'b1, 1'b0);
        step(1'b0, SLOTS - 1, DW'($urandom), 1'b1, 1'b0);
        check("overrun_pulse", err_overrun, 1);
        for (int t = SLOTS; t < FRAME; t++) step(1'b0, t, DW'($urandom), 1'b1, 1'b0);
        for (int t = 0; t < 30; t++) step(1'b0, t, DW'($urandom), 1'b1, 1'b0);
        step(1'b1, 30, DW'($urandom), 1'b1, 1'b0);
        repeat (2) frame(-1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
